// File: rtl/mempool_l2_banked_mem.sv
// Word-interleaved multi-bank L2 scratchpad with valid/ready request and
// response channels. One registered in-flight stage feeds a fall-through
// response FIFO. A credit counter bounds outstanding requests to the FIFO
// depth, so a response never has to be dropped.
module mempool_l2_banked_mem #(
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned NumBanks      = 4,
   parameter int unsigned BankAddrWidth = 16,
   parameter int unsigned RespFifoDepth = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [AddrWidth-1:0]   req_addr_i,
   input  logic                   req_we_i,
   input  logic [DataWidth-1:0]   req_wdata_i,
   input  logic [DataWidth/8-1:0] req_be_i,
   output logic                   resp_valid_o,
   input  logic                   resp_ready_i,
   output logic [DataWidth-1:0]   resp_rdata_o,
   output logic                   resp_err_o,
   output logic                   busy_o
);

   localparam int unsigned BeWidth  = DataWidth / 8;
   localparam int unsigned ByteOff  = $clog2(BeWidth);
   localparam int unsigned BankBits = $clog2(NumBanks);
   localparam int unsigned BankIdxW = (NumBanks > 1) ? BankBits : 1;
   localparam int unsigned TopBit   = ByteOff + BankBits + BankAddrWidth;
   localparam int unsigned PtrW     = $clog2(RespFifoDepth);
   localparam int unsigned CntW     = $clog2(RespFifoDepth + 1);
   localparam int unsigned NumRows  = 2 ** BankAddrWidth;

   // ---------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------
   logic [AddrWidth-1:0]     word_addr;
   logic [BankIdxW-1:0]      req_bank;
   logic [BankAddrWidth-1:0] req_row;
   logic                     req_err;
   logic                     accept;
   logic [NumBanks-1:0]      bank_req;

   // Split the byte address into bank / row and flag out-of-range accesses.
   always_comb begin
      word_addr = req_addr_i >> ByteOff;
      req_bank  = BankIdxW'(word_addr & AddrWidth'(NumBanks - 1));
      req_row   = BankAddrWidth'(word_addr >> BankBits);
      req_err   = (req_addr_i >> TopBit) != '0;
      accept    = req_valid_i & req_ready_o;
      bank_req  = '0;
      if (accept && !req_err) begin
         bank_req[req_bank] = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Banks: one-cycle read latency, byte-masked writes, contents not reset
   // ---------------------------------------------------------------------
   logic [DataWidth-1:0] bank_rdata [NumBanks];

   for (genvar b = 0; b < NumBanks; b++) begin : g_bank
      logic [DataWidth-1:0] mem_q [NumRows];
      logic [DataWidth-1:0] rdata_q;

      // Single-port SRAM behaviour: write bytes or capture the addressed row.
      always_ff @(posedge clk_i) begin
         if (bank_req[b]) begin
            if (req_we_i) begin
               for (int i = 0; i < BeWidth; i++) begin
                  if (req_be_i[i]) begin
                     mem_q[req_row][8*i +: 8] <= req_wdata_i[8*i +: 8];
                  end
               end
            end else begin
               rdata_q <= mem_q[req_row];
            end
         end
      end

      assign bank_rdata[b] = rdata_q;
   end

   // ---------------------------------------------------------------------
   // In-flight stage
   // ---------------------------------------------------------------------
   logic                infl_valid_q, infl_valid_d;
   logic                infl_err_q,   infl_err_d;
   logic                infl_we_q,    infl_we_d;
   logic [BankIdxW-1:0] infl_bank_q,  infl_bank_d;

   // Remember what was accepted so the right bank output is picked next cycle.
   always_comb begin
      infl_valid_d = accept;
      infl_err_d   = req_err;
      infl_we_d    = req_we_i;
      infl_bank_d  = req_bank;
   end

   // In-flight stage registers; a reset drops whatever was in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         infl_valid_q <= 1'b0;
         infl_err_q   <= 1'b0;
         infl_we_q    <= 1'b0;
         infl_bank_q  <= '0;
      end else begin
         infl_valid_q <= infl_valid_d;
         infl_err_q   <= infl_err_d;
         infl_we_q    <= infl_we_d;
         infl_bank_q  <= infl_bank_d;
      end
   end

   // ---------------------------------------------------------------------
   // Fall-through response FIFO
   // ---------------------------------------------------------------------
   logic [DataWidth-1:0] fifo_rdata_q [RespFifoDepth];
   logic                 fifo_err_q   [RespFifoDepth];
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]      fifo_cnt_q, fifo_cnt_d;
   logic [DataWidth-1:0] push_rdata;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 pop;
   logic                 bypass;
   logic                 fifo_wr;
   logic                 fifo_rd;

   // Response path: stored head first, otherwise the entry arriving this cycle.
   always_comb begin
      push_rdata = (infl_err_q || infl_we_q) ? '0 : bank_rdata[infl_bank_q];
      fifo_empty = (fifo_cnt_q == '0);
      fifo_full  = (fifo_cnt_q == CntW'(RespFifoDepth));

      resp_valid_o = !fifo_empty || infl_valid_q;
      resp_rdata_o = '0;
      resp_err_o   = 1'b0;
      if (!fifo_empty) begin
         resp_rdata_o = fifo_rdata_q[rd_ptr_q];
         resp_err_o   = fifo_err_q[rd_ptr_q];
      end else if (infl_valid_q) begin
         resp_rdata_o = push_rdata;
         resp_err_o   = infl_err_q;
      end

      pop     = resp_valid_o && resp_ready_i;
      bypass  = fifo_empty && infl_valid_q && pop;
      fifo_wr = infl_valid_q && !bypass;
      fifo_rd = pop && !fifo_empty;

      wr_ptr_d = wr_ptr_q;
      if (fifo_wr) begin
         wr_ptr_d = (wr_ptr_q == PtrW'(RespFifoDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      rd_ptr_d = rd_ptr_q;
      if (fifo_rd) begin
         rd_ptr_d = (rd_ptr_q == PtrW'(RespFifoDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end

      fifo_cnt_d = fifo_cnt_q;
      case ({fifo_wr, fifo_rd})
         2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   // FIFO pointers and fill level.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

   // FIFO storage; never read while empty, so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (fifo_wr) begin
         fifo_rdata_q[wr_ptr_q] <= push_rdata;
         fifo_err_q[wr_ptr_q]   <= infl_err_q;
      end
   end

   // ---------------------------------------------------------------------
   // Credit counter: in-flight plus stored responses
   // ---------------------------------------------------------------------
   logic [CntW-1:0] cnt_q, cnt_d;

   // Count accepts up and response handshakes down.
   always_comb begin
      cnt_d = cnt_q;
      case ({accept, pop})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
      req_ready_o = (cnt_q < CntW'(RespFifoDepth));
      busy_o      = (cnt_q != '0);
   end

   // Credit counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The credit scheme must keep the FIFO from ever being written when full.
   fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(fifo_wr && fifo_full));

endmodule
